seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexes one BCD-to-seven-segment decode path across NUM_DIGITS common-anode digits that share one segment bus.
- Holds a shadow copy of the displayed value, accepts new values through a valid/ready handshake, and applies them only at frame boundaries so a frame never mixes old and new digits.
- Inserts a short all-digits-off gap at each digit change to suppress ghosting.
- Sits between the ALU result logic and the board's segment/anode pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 15 +
 rtl/seven_seg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Value handshake and display pins of the seven-segment scan controller.
// The master drives enable/load/value; the slave returns ready and the segment/anode buses.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    ready;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (output enable, load, value, input ready, seg, an);
    modport slave  (input enable, load, value, output ready, seg, an);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed BCD seven-segment scanner with a shadow value swapped only at frame boundaries.
// Latency: seg/an registered one cycle after the slot counters; optional SEVEN_SEG_LEADING_ZERO_BLANK_EN.
// Backpressure: ready drops after a capture and rises the cycle after the next frame boundary.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [IW-1:0]               idx;
    logic [NUM_DIGITS-1:0][3:0]  shadow;
    logic [NUM_DIGITS-1:0][3:0]  pending;
    logic                        ready;
    logic                        loaded;
    logic [6:0]                  seg;
    logic [NUM_DIGITS-1:0]       an;

    logic                        boundary;
    logic                        hide;
    logic [6:0]                  seg_nxt;
    logic [NUM_DIGITS-1:0]       an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every digit above it are zero; digit 0 is never suppressed
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic above;
        above = 1'b1;
        lz    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above = above && (shadow[i] == 4'h0);
            lz[i] = above;
        end
    end
`endif

    always_comb begin
        boundary = (state == IDLE) || (idx == IDX_LAST && cnt == CNT_LAST);
        hide     = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        hide     = lz[idx];
`endif
        seg_nxt  = hide ? 7'b1111111 : decode(shadow[idx]);
        an_nxt   = '1;
        if (cnt >= CNT_BLANK && !hide)
            an_nxt[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shadow  <= {NUM_DIGITS{4'hF}};
            pending <= {NUM_DIGITS{4'hF}};
            ready   <= 1'b1;
            loaded  <= 1'b0;
            seg     <= 7'b1111111;
            an      <= '1;
        end else begin
            // ready low means pending holds a value captured on an earlier cycle
            if (bus.load && ready) begin
                pending <= bus.value;
                ready   <= 1'b0;
            end else if (!ready && boundary) begin
                shadow  <= pending;
                ready   <= 1'b1;
                loaded  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (bus.enable && loaded)
                        state <= SCAN;
                end
                SCAN: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == SCAN && bus.enable) begin
                seg <= seg_nxt;
                an  <= an_nxt;
            end else begin
                seg <= 7'b1111111;
                an  <= '1;
            end
        end
    end

    assign bus.ready = ready;
    assign bus.seg   = seg;
    assign bus.an    = an;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: a frame-position reference model queues the expected pins per cycle,
// and a negedge monitor pops and compares them against the scanner.
module tb_seven_seg_scan_ctrl;
    localparam int N = 4;
    localparam int D = 8;
    localparam int B = 2;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic       ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(N)) ifc ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .DWELL_CYCLES(D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] segtab[16];

    // reference model: one position counter across the whole frame
    bit         m_scan, m_ready, m_loaded;
    int         m_pos;
    logic [3:0] m_sh[N];
    logic [3:0] m_pd[N];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() >= 2) begin
            exp_t x;
            x = q.pop_front();
            chk("seg",   {1'b0, ifc.seg},   {1'b0, x.seg});
            chk("an",    {4'b0, ifc.an},    {4'b0, x.an});
            chk("ready", {7'b0, ifc.ready}, {7'b0, x.ready});
        end
    end

    task automatic model(input bit r, input bit e, input bit l, input logic [15:0] v);
        exp_t x;
        int   idx, cnt;
        bit   bnd, hide, was_loaded;
        x.seg = 7'h7F; x.an = 4'hF; x.ready = 1'b1;
        if (!r) begin
            m_scan = 0; m_pos = 0; m_ready = 1; m_loaded = 0;
            for (int i = 0; i < N; i++) begin m_sh[i] = 4'hF; m_pd[i] = 4'hF; end
        end else begin
            idx = (m_pos / D) % N;
            cnt = m_pos % D;
            bnd = !m_scan || (m_pos == N * D - 1);
            if (m_scan && e) begin
                hide = LZB && idx > 0;
                for (int j = idx; j < N; j++)
                    if (m_sh[j] != 4'h0) hide = 0;
                x.seg = hide ? 7'h7F : segtab[m_sh[idx]];
                x.an  = (cnt < B || hide) ? 4'hF : ~(4'b0001 << idx);
            end
            was_loaded = m_loaded;
            if (l && m_ready) begin
                for (int i = 0; i < N; i++) m_pd[i] = v[4*i +: 4];
                m_ready = 0;
            end else if (!m_ready && bnd) begin
                for (int i = 0; i < N; i++) m_sh[i] = m_pd[i];
                m_ready  = 1;
                m_loaded = 1;
            end
            x.ready = m_ready;
            if (!m_scan) begin
                m_scan = e && was_loaded;
                m_pos  = 0;
            end else if (!e) begin
                m_scan = 0;
                m_pos  = 0;
            end else begin
                m_pos = (m_pos + 1) % (N * D);
            end
        end
        q.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input bit l, input logic [15:0] v);
        rst_n = r; ifc.enable = e; ifc.load = l; ifc.value = v;
        model(r, e, l, v);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(1, e, 0, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        segtab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                   7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        // reset, then enable without any load stays dark
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0000);
        run(12, 1);
        // first load from idle, then scan through a frame
        step(1, 1, 1, 16'h1234);
        run(40, 1);
        // mid-frame load, second load while busy is ignored
        step(1, 1, 1, 16'h5678);
        step(1, 1, 1, 16'h9999);
        run(80, 1);
        // blank codes and zeros
        step(1, 1, 1, 16'h00AF);
        run(70, 1);
        // leading zeros
        step(1, 1, 1, 16'h0050);
        run(70, 1);
        // drop enable mid digit 2, re-enable, then reset with a pending value
        for (int i = 0; i < 64 && !(m_scan && (m_pos / D) % N == 2 && m_pos % D == 4); i++)
            run(1, 1);
        run(3, 0);
        run(40, 1);
        step(1, 1, 1, 16'h4321);
        run(2, 1);
        step(0, 1, 0, 16'h0000);
        run(20, 1);
        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < N; d++)
                v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 149) != 0),
                 ($urandom_range(0, 19) == 0), v);
        end
        run(4, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
